// File: rtl/edge_bbox_tracker.sv
// Edge bounding-box tracker. Thresholds the Sobel edge-magnitude stream,
// qualifies edges by horizontal run length, and publishes a per-frame
// bounding box plus a saturating qualified-pixel count.
module edge_bbox_tracker #(
  parameter int RUN_LEN = 3,
  parameter int XW      = 11,
  parameter int YW      = 11,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       edge_mag,
  input  logic             in_valid,
  input  logic             packet_video,
  input  logic             sop,
  input  logic             eop,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [7:0]       threshold,
  output logic [XW-1:0]    bb_x_min,
  output logic [XW-1:0]    bb_x_max,
  output logic [YW-1:0]    bb_y_min,
  output logic [YW-1:0]    bb_y_max,
  output logic             bb_found,
  output logic [CNT_W-1:0] edge_count,
  output logic             bb_valid
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PUBLISH} state_t;

  localparam logic [3:0]    RL    = 4'(RUN_LEN);
  localparam logic [XW-1:0] RL_M1 = XW'(RUN_LEN - 1);

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [7:0]       thr_q, thr_d;
  logic [XW-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XW-1:0]    bb_x_min_q, bb_x_min_d, bb_x_max_q, bb_x_max_d;
  logic [YW-1:0]    bb_y_min_q, bb_y_min_d, bb_y_max_q, bb_y_max_d;
  logic             bb_found_q, bb_found_d, bb_valid_q, bb_valid_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;

  logic             accept, start, proc, hit, qual, found;
  logic [7:0]       thr_use;
  logic [3:0]       run_nxt;
  logic [XW-1:0]    x_lo;

  // Frame control, pixel processing and publish; the output registers are
  // loaded on the eop edge so bb_valid is high during the PUBLISH cycle.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    thr_d        = thr_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    cnt_d        = cnt_q;
    bb_x_min_d   = bb_x_min_q;
    bb_x_max_d   = bb_x_max_q;
    bb_y_min_d   = bb_y_min_q;
    bb_y_max_d   = bb_y_max_q;
    bb_found_d   = bb_found_q;
    edge_count_d = edge_count_q;
    bb_valid_d   = 1'b0;
    hit          = 1'b0;
    qual         = 1'b0;
    found        = 1'b0;
    run_nxt      = '0;
    thr_use      = thr_q;
    x_lo         = x - RL_M1;

    accept = in_valid && packet_video;
    // sop starts a frame in every state (restart when already ACTIVE)
    start  = accept && sop;
    proc   = accept && (sop || (state_q == ACTIVE));

    if (start) begin
      thr_d   = threshold;
      thr_use = threshold;
      run_d   = '0;
      xmin_d  = '1;
      xmax_d  = '0;
      ymin_d  = '1;
      ymax_d  = '0;
      cnt_d   = '0;
    end

    if (proc) begin
      hit = (edge_mag >= thr_use);
      if (!hit)             run_nxt = '0;
      else if (x == '0)     run_nxt = 4'd1;
      else if (run_d >= RL) run_nxt = RL;
      else                  run_nxt = run_d + 4'd1;
      run_d = run_nxt;
      qual  = (run_nxt == RL);
      if (qual) begin
        if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
        if (x > xmax_d)    xmax_d = x;
        if (x_lo < xmin_d) xmin_d = x_lo;
        if (y > ymax_d)    ymax_d = y;
        if (y < ymin_d)    ymin_d = y;
      end
    end

    if (proc && eop) begin
      state_d      = PUBLISH;
      bb_valid_d   = 1'b1;
      found        = (cnt_d != '0);
      bb_found_d   = found;
      edge_count_d = cnt_d;
      bb_x_min_d   = found ? xmin_d : '0;
      bb_x_max_d   = found ? xmax_d : '0;
      bb_y_min_d   = found ? ymin_d : '0;
      bb_y_max_d   = found ? ymax_d : '0;
    end else if (start) begin
      state_d = ACTIVE;
    end else if (state_q == PUBLISH) begin
      state_d = IDLE;
    end
  end

  // State, accumulator and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      run_q        <= '0;
      thr_q        <= '0;
      xmin_q       <= '1;
      xmax_q       <= '0;
      ymin_q       <= '1;
      ymax_q       <= '0;
      cnt_q        <= '0;
      bb_x_min_q   <= '0;
      bb_x_max_q   <= '0;
      bb_y_min_q   <= '0;
      bb_y_max_q   <= '0;
      bb_found_q   <= 1'b0;
      edge_count_q <= '0;
      bb_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      thr_q        <= thr_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cnt_q        <= cnt_d;
      bb_x_min_q   <= bb_x_min_d;
      bb_x_max_q   <= bb_x_max_d;
      bb_y_min_q   <= bb_y_min_d;
      bb_y_max_q   <= bb_y_max_d;
      bb_found_q   <= bb_found_d;
      edge_count_q <= edge_count_d;
      bb_valid_q   <= bb_valid_d;
    end
  end

  assign bb_x_min   = bb_x_min_q;
  assign bb_x_max   = bb_x_max_q;
  assign bb_y_min   = bb_y_min_q;
  assign bb_y_max   = bb_y_max_q;
  assign bb_found   = bb_found_q;
  assign edge_count = edge_count_q;
  assign bb_valid   = bb_valid_q;

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Bench for edge_bbox_tracker: directed frames plus randomized frames, checked
// every cycle against a frame-level reference model.
module tb_edge_bbox_tracker;
  localparam int RUN_LEN = 3;
  localparam int XW = 11, YW = 11, CNT_W = 20;

  logic             clk = 0, reset = 1;
  logic [7:0]       edge_mag = 0, threshold = 0;
  logic             in_valid = 0, packet_video = 0, sop = 0, eop = 0;
  logic [XW-1:0]    x = 0;
  logic [YW-1:0]    y = 0;
  logic [XW-1:0]    bb_x_min, bb_x_max;
  logic [YW-1:0]    bb_y_min, bb_y_max;
  logic             bb_found, bb_valid;
  logic [CNT_W-1:0] edge_count;

  int vectors = 0, miscompares = 0;

  edge_bbox_tracker #(.RUN_LEN(RUN_LEN), .XW(XW), .YW(YW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .edge_mag(edge_mag), .in_valid(in_valid),
    .packet_video(packet_video), .sop(sop), .eop(eop), .x(x), .y(y),
    .threshold(threshold), .bb_x_min(bb_x_min), .bb_x_max(bb_x_max),
    .bb_y_min(bb_y_min), .bb_y_max(bb_y_max), .bb_found(bb_found),
    .edge_count(edge_count), .bb_valid(bb_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A frame is the list of accepted beats since sop; at eop a pixel qualifies
  // when it and the RUN_LEN-1 accepted beats before it are all hits and no
  // line start (x == 0) occurs after the first beat of that window.
  bit   started = 0, in_frame = 0;
  logic [7:0] m_thr;
  bit   hq[$];
  int   xq[$], yq[$];
  logic e_valid = 0, e_found = 0;
  int   e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_cnt = 0;

  task automatic evaluate_frame();
    int cnt = 0, xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1;
    for (int i = RUN_LEN - 1; i < hq.size(); i++) begin
      bit ok = 1;
      for (int k = i - RUN_LEN + 1; k <= i; k++) if (!hq[k]) ok = 0;
      for (int k = i - RUN_LEN + 2; k <= i; k++) if (xq[k] == 0) ok = 0;
      if (ok) begin
        if (cnt < (1 << CNT_W) - 1) cnt++;
        if (xq[i] > xmx) xmx = xq[i];
        if (xq[i] - (RUN_LEN - 1) < xmn) xmn = xq[i] - (RUN_LEN - 1);
        if (yq[i] > ymx) ymx = yq[i];
        if (yq[i] < ymn) ymn = yq[i];
      end
    end
    e_cnt   = cnt;
    e_found = (cnt != 0);
    e_xmin  = e_found ? xmn : 0;
    e_xmax  = e_found ? xmx : 0;
    e_ymin  = e_found ? ymn : 0;
    e_ymax  = e_found ? ymx : 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      started = 1; in_frame = 0; e_valid = 0; e_found = 0;
      e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
    end else begin
      e_valid = 0;
      if (in_valid && packet_video) begin
        if (sop) begin
          in_frame = 1; m_thr = threshold;
          hq.delete(); xq.delete(); yq.delete();
        end
        if (in_frame) begin
          hq.push_back(edge_mag >= m_thr);
          xq.push_back(int'(x));
          yq.push_back(int'(y));
          if (eop) begin
            evaluate_frame();
            e_valid = 1; in_frame = 0;
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if (bb_valid !== e_valid || bb_found !== e_found ||
          bb_x_min !== XW'(e_xmin) || bb_x_max !== XW'(e_xmax) ||
          bb_y_min !== YW'(e_ymin) || bb_y_max !== YW'(e_ymax) ||
          edge_count !== CNT_W'(e_cnt)) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got v=%b f=%b x=%0d..%0d y=%0d..%0d c=%0d want v=%b f=%b x=%0d..%0d y=%0d..%0d c=%0d",
                 $time, bb_valid, bb_found, bb_x_min, bb_x_max, bb_y_min, bb_y_max, edge_count,
                 e_valid, e_found, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int img[0:7][0:15];

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic chk_box(input string name, input int v, input int f, input int x0,
                         input int x1, input int y0, input int y1, input int c);
    chk({name, ".valid"}, int'(bb_valid), v);
    chk({name, ".found"}, int'(bb_found), f);
    chk({name, ".xmin"},  int'(bb_x_min), x0);
    chk({name, ".xmax"},  int'(bb_x_max), x1);
    chk({name, ".ymin"},  int'(bb_y_min), y0);
    chk({name, ".ymax"},  int'(bb_y_max), y1);
    chk({name, ".count"}, int'(edge_count), c);
  endtask

  task automatic drive(input int m, input int xx, input int yy, input bit s,
                       input bit e, input bit v, input bit pv);
    edge_mag = 8'(m); x = XW'(xx); y = YW'(yy);
    sop = s; eop = e; in_valid = v; packet_video = pv;
    @(posedge clk); #1;
    in_valid = 0; sop = 0; eop = 0; packet_video = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_img();
    foreach (img[i, j]) img[i][j] = 0;
  endtask

  // Raster-order frame from img; optional in_valid gaps and non-video beats
  // (never before the first beat), optional threshold change after sop.
  task automatic send_frame(input int w, input int h, input int thr, input int gap_pct,
                            input int nv_pct, input bit thr_mid, input bit no_eop);
    threshold = 8'(thr);
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        if (xx != 0 || yy != 0) begin
          while ($urandom_range(99) < gap_pct)
            drive(255, xx, yy, 0, 0, 0, 1);
          while ($urandom_range(99) < nv_pct)
            drive(255, xx, yy, $urandom_range(1), $urandom_range(1), 1, 0);
        end
        drive(img[yy][xx], xx, yy, (xx == 0 && yy == 0), !no_eop && (xx == w-1 && yy == h-1), 1, 1);
        if (thr_mid && xx == 0 && yy == 0) threshold = ~threshold;
      end
  endtask

  initial begin
    // Reset then idle
    reset = 1; idle(3); reset = 0;
    chk_box("reset", 0, 0, 0, 0, 0, 0, 0);
    drive(255, 3, 0, 0, 1, 1, 1);          // eop-only in IDLE
    chk("idle_eop_no_pulse", int'(bb_valid), 0);
    idle(3);

    // 8x4 basic frame
    clr_img(); for (int i = 3; i <= 6; i++) img[2][i] = 50;
    send_frame(8, 4, 40, 0, 0, 0, 0);
    chk_box("basic", 1, 1, 3, 6, 2, 2, 2);
    idle(1);
    chk("pulse_one_cycle", int'(bb_valid), 0);
    chk("hold_xmax", int'(bb_x_max), 6);

    // Noise: isolated pairs only, with gaps
    clr_img();
    img[0][1] = 200; img[0][2] = 200; img[1][5] = 200; img[1][6] = 200;
    img[2][0] = 200; img[2][1] = 200; img[3][4] = 200; img[3][5] = 200;
    send_frame(8, 4, 100, 40, 0, 0, 0);
    chk_box("noise", 1, 0, 0, 0, 0, 0, 0);

    // Run of 3 split by in_valid gaps still qualifies
    clr_img(); for (int i = 2; i <= 4; i++) img[0][i] = 200;
    send_frame(8, 2, 100, 60, 0, 0, 0);
    chk_box("split_run", 1, 1, 2, 4, 0, 0, 1);

    // Line wrap breaks the run; non-video beats ignored
    clr_img(); img[1][6] = 255; img[1][7] = 255; img[2][0] = 255;
    send_frame(8, 3, 100, 10, 40, 0, 0);
    chk_box("line_wrap", 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Restart mid-frame: first frame's hits discarded
    clr_img(); for (int i = 0; i < 8; i++) img[3][i] = 255;
    send_frame(8, 4, 10, 0, 0, 0, 1);
    clr_img(); for (int i = 1; i <= 4; i++) img[1][i] = 90;
    send_frame(8, 3, 80, 0, 0, 0, 0);
    chk_box("restart", 1, 1, 1, 4, 1, 1, 2);

    // Back-to-back: second sop lands in the PUBLISH cycle
    clr_img(); for (int i = 0; i <= 5; i++) img[0][i] = 150;
    send_frame(6, 2, 120, 0, 0, 0, 0);
    chk_box("b2b_first", 1, 1, 0, 5, 0, 0, 4);
    clr_img(); for (int i = 3; i <= 5; i++) begin img[2][i] = 60; img[4][i] = 60; end
    send_frame(6, 5, 60, 0, 0, 0, 0);
    chk_box("b2b_second", 1, 1, 3, 5, 2, 4, 2);

    // Single-beat frame
    drive(255, 0, 0, 1, 1, 1, 1);
    chk_box("single_beat", 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Reset mid-frame after hits
    clr_img(); for (int i = 0; i < 8; i++) img[0][i] = 255;
    send_frame(8, 2, 10, 0, 0, 0, 1);
    reset = 1; idle(1); reset = 0;
    chk_box("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("mid_reset_no_pulse", int'(bb_valid), 0);

    // Threshold change after sop is ignored
    clr_img(); for (int i = 2; i <= 5; i++) img[1][i] = 50;
    send_frame(8, 3, 40, 0, 0, 1, 0);
    chk_box("thr_mid", 1, 1, 2, 5, 1, 1, 2);
    idle(1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int w = $urandom_range(16, 1), h = $urandom_range(8, 1);
      clr_img();
      foreach (img[i, j])
        img[i][j] = ($urandom_range(3) != 0) ? $urandom_range(255, 120) : $urandom_range(119);
      send_frame(w, h, $urandom_range(200, 60), $urandom_range(30), $urandom_range(20),
                 $urandom_range(1), ($urandom_range(9) == 0));
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
